sram_mp_ctrl: RTL and testbench
===============================

Name: sram_mp_ctrl

Overview:
- Parametrised multi-port controller for the on-board asynchronous 32-bit SRAM; successor to the fixed 4-phase single-read/single-write controller.
- Serves N_RD independent read clients (VGA scan-out, maze logic, etc.) and one write client over a shared SRAM bus.
- Uses a req/ack/valid handshake instead of free-running time slots.
- Arbitration: write has priority; reads are served round-robin. Access timing is stretched by a wait-state parameter.

Parameters:
- DATA_W, 32, SRAM data width.
- ADDR_W, 20, SRAM word-address width.
- N_RD, 2, number of read channels (1..8).
- WAIT_CYC, 0, extra clk_100m cycles added to each OE/WE strobe (0..7).

Ports:
- clk_100m  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rd_req  in  N_RD  per-channel read request, level; held until rd_ack.
- rd_addr  in  N_RD*ADDR_W  packed read addresses; channel i at [i*ADDR_W +: ADDR_W].
- rd_ack  out  N_RD  one-cycle grant pulse; address sampled this cycle.
- rd_data  out  N_RD*DATA_W  per-channel read data register.
- rd_valid  out  N_RD  one-cycle pulse; rd_data of that channel updated.
- wr_req  in  1  write request, level; held until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle grant pulse; addr/data sampled this cycle.
- wr_done  out  1  one-cycle pulse when the write strobe sequence completes.
- ram_data  inout  DATA_W  SRAM data bus; driven only in write states, else Z.
- ram_addr  out  ADDR_W  SRAM address.
- ram_ce_n  out  1  chip enable, tied 0.
- ram_oe_n  out  1  output enable, active low.
- ram_we_n  out  1  write enable, active low.

Behaviour:
- Reset (async, immediate), all registered outputs:
  - ram_oe_n=1, ram_we_n=1, ram_addr=0, bus released.
  - rd_ack, rd_valid, wr_ack, wr_done = 0; rd_data = 0.
  - Round-robin pointer = 0; state IDLE.
- Reset mid-access aborts the access; no rd_valid or wr_done is produced for it.
- FSM states: IDLE, RD_STROBE, RD_CAP, WR_SETUP, WR_STROBE, WR_HOLD.
- IDLE (all strobes high, bus Z):
  - If wr_req: pulse wr_ack, latch addr/data, go to WR_SETUP.
  - Else if any rd_req: grant the lowest-index requesting channel at or after the pointer (wrap from N_RD-1 to 0). Pulse rd_ack[i], latch rd_addr i, set pointer=(i+1) mod N_RD, go to RD_STROBE.
  - Else stay in IDLE.
- RD_STROBE: ram_addr=latched, ram_oe_n=0 for WAIT_CYC+1 cycles, then RD_CAP.
- RD_CAP: ram_oe_n=1; sample ram_data into rd_data slice i; pulse rd_valid[i]; go to IDLE.
  - Read latency: ack cycle to rd_valid cycle = WAIT_CYC+2 cycles.
- WR_SETUP: 1 cycle; ram_addr and ram_data driven, ram_we_n=1.
- WR_STROBE: ram_we_n=0 for WAIT_CYC+1 cycles; addr/data held.
- WR_HOLD: 1 cycle; ram_we_n=1, data still driven; pulse wr_done; go to IDLE.
- The IDLE cycle between accesses is the mandatory bus turnaround. ram_oe_n and ram_we_n are never low in the same cycle.
- At most one ack pulses per cycle.
- A request deasserted before its ack is dropped silently; inputs sampled only at ack.
- A requester may re-raise its request in the cycle of its rd_valid/wr_done; it is arbitrated at the next IDLE.
- Continuous wr_req may starve reads; this is the caller's responsibility.
- Wait-state counter is 3 bits; it reloads on every strobe entry.

Optional Feature:
- Macro SRAM_MP_RD_BYPASS_EN.
- When defined: a read whose address equals the write address latched in the most recent completed write (valid flag set by wr_done, cleared by rst) skips the SRAM. It goes IDLE->RD_CAP directly, rd_data = latched write data, latency 1 cycle after ack, ram_oe_n stays 1.
- When undefined: every read uses the SRAM strobe path.

Test Plan:
- Reset with WAIT_CYC=0, no requests -> ram_oe_n=1, ram_we_n=1, bus Z, all acks/valids 0 for 10 cycles.
- wr_req addr 0x00010, data 0xDEADBEEF, then rd_req[0] addr 0x00010 -> wr_ack, WE low exactly 1 cycle, wr_done; rd_ack[0], rd_valid[0] 2 cycles later, rd_data[0]=0xDEADBEEF.
- WAIT_CYC=3, single read -> ram_oe_n low 4 cycles, rd_valid 5 cycles after rd_ack.
- N_RD=3, rd_req=3'b111 held continuously -> grant order 0,1,2,0,1,2; each new rd_ack 1 cycle after the previous rd_valid.
- wr_req and rd_req[1] rising in the same cycle -> wr_ack first; rd_ack[1] in the IDLE after wr_done; OE/WE never simultaneously low.
- rst asserted during WR_STROBE -> ram_we_n=1 and bus Z immediately, no wr_done; after release, a new read completes normally.

Source files
------------

// File: rtl/sram_mp_ctrl.sv
// sram_mp_ctrl: round-robin N-read / 1-write controller for async SRAM.
// Optional same-address read bypass: define SRAM_MP_RD_BYPASS_EN.
module sram_mp_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 20,
  parameter int N_RD     = 2,
  parameter int WAIT_CYC = 0
) (
  input  logic                   clk_100m,
  input  logic                   rst,
  input  logic [N_RD-1:0]        rd_req,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_ack,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_valid,
  input  logic                   wr_req,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ack,
  output logic                   wr_done,
  inout  wire  [DATA_W-1:0]      ram_data,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_ce_n,
  output logic                   ram_oe_n,
  output logic                   ram_we_n
);

  localparam int PW = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_CAP,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_t;

  state_t state;

  logic [2:0]        cnt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     nxt;
  logic              found;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] cap;
  logic              ram_drive;
  int                rank;
  int                best;

`ifdef SRAM_MP_RD_BYPASS_EN
  logic [ADDR_W-1:0] byp_addr;
  logic [DATA_W-1:0] byp_data;
  logic              byp_vld;
  logic              byp_hit;

  assign byp_hit = byp_vld && (pick_addr == byp_addr);
`endif

  assign ram_ce_n = 1'b0;
  assign ram_data = ram_drive ? wdat : 'z;

  // Rank each requester by its distance from the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    best  = N_RD;
    rank  = 0;
    for (int i = 0; i < N_RD; i++) begin
      rank = i - int'(ptr);
      if (rank < 0) rank = rank + N_RD;
      if (rd_req[i] && rank < best) begin
        best  = rank;
        pick  = PW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (PW'(i) == pick)
        pick_addr = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign nxt = (int'(pick) == N_RD - 1) ? '0 : pick + 1'b1;

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      sel       <= '0;
      ram_addr  <= '0;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_drive <= 1'b0;
      wdat      <= '0;
      cap       <= '0;
      rd_ack    <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      wr_ack    <= 1'b0;
      wr_done   <= 1'b0;
`ifdef SRAM_MP_RD_BYPASS_EN
      byp_addr  <= '0;
      byp_data  <= '0;
      byp_vld   <= 1'b0;
`endif
    end else begin
      rd_ack   <= '0;
      rd_valid <= '0;
      wr_ack   <= 1'b0;
      wr_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            wr_ack    <= 1'b1;
            ram_addr  <= wr_addr;
            wdat      <= wr_data;
            ram_drive <= 1'b1;
            state     <= WR_SETUP;
          end else if (found) begin
            rd_ack[pick] <= 1'b1;
            sel          <= pick;
            ptr          <= nxt;
            ram_addr     <= pick_addr;
`ifdef SRAM_MP_RD_BYPASS_EN
            if (byp_hit) begin
              cap   <= byp_data;
              state <= RD_CAP;
            end else begin
              ram_oe_n <= 1'b0;
              cnt      <= WAIT_LD;
              state    <= RD_STROBE;
            end
`else
            ram_oe_n <= 1'b0;
            cnt      <= WAIT_LD;
            state    <= RD_STROBE;
`endif
          end
        end
        RD_STROBE: begin
          // Sample on the last OE-low edge, while the SRAM still drives.
          if (cnt == 3'd0) begin
            ram_oe_n <= 1'b1;
            cap      <= ram_data;
            state    <= RD_CAP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RD_CAP: begin
          rd_data[int'(sel)*DATA_W +: DATA_W] <= cap;
          rd_valid[sel] <= 1'b1;
          state         <= IDLE;
        end
        WR_SETUP: begin
          ram_we_n <= 1'b0;
          cnt      <= WAIT_LD;
          state    <= WR_STROBE;
        end
        WR_STROBE: begin
          if (cnt == 3'd0) begin
            ram_we_n <= 1'b1;
            wr_done  <= 1'b1;
            state    <= WR_HOLD;
`ifdef SRAM_MP_RD_BYPASS_EN
            byp_addr <= ram_addr;
            byp_data <= wdat;
            byp_vld  <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WR_HOLD: begin
          ram_drive <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overlap: assert property (
    @(posedge clk_100m) disable iff (rst)
    !(!ram_oe_n && !ram_we_n));

  a_one_ack: assert property (
    @(posedge clk_100m) disable iff (rst)
    $onehot0({rd_ack, wr_ack}));

  a_no_fight: assert property (
    @(posedge clk_100m) disable iff (rst)
    !(ram_drive && !ram_oe_n));

endmodule

// File: tb/tb_sram_mp_ctrl.sv
// tb_sram_mp_ctrl: directed vector bench for sram_mp_ctrl
// (N_RD=3, WAIT_CYC=1) with a 256-word SRAM model.
module tb_sram_mp_ctrl;

  localparam int W  = 1;
  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 32;
`ifdef SRAM_MP_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [1:0]  ch;
    logic [19:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  rd_req = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N-1:0]  rd_ack;
  logic [N*DW-1:0] rd_data;
  logic [N-1:0]  rd_valid;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          wr_done;
  wire  [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_ce_n;
  logic          ram_oe_n;
  logic          ram_we_n;

  logic [31:0] mem [256];
  int   n_vec = 0;
  int   n_err = 0;
  bit   overlap = 1'b0;
  bit   multi = 1'b0;
  bit   tb_wv = 1'b0;
  logic [19:0] tb_wa = '0;
  vec_t vecs [10];

  sram_mp_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .N_RD(N), .WAIT_CYC(W)
  ) dut (
    .clk_100m(clk),
    .rst(rst),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .wr_done(wr_done),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  // Async SRAM model: low 8 address bits decoded.
  assign ram_data = !ram_oe_n ? mem[ram_addr[7:0]] : 'z;

  always @(negedge clk) begin
    if (!ram_we_n) mem[ram_addr[7:0]] = ram_data;
    if (!rst) begin
      if (!ram_oe_n && !ram_we_n) overlap = 1'b1;
      if ($countones({rd_ack, wr_ack}) > 1) multi = 1'b1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit byp(input logic [19:0] a);
    return BYP && tb_wv && (a == tb_wa);
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int t_ack, t_fin, n_stb, lat, stb;
    bit bp;
    t_ack = -1;
    t_fin = -1;
    n_stb = 0;
    bp = !v.wr && byp(v.addr);
    @(negedge clk);
    if (v.wr) begin
      wr_addr = v.addr;
      wr_data = v.data;
      wr_req  = 1'b1;
    end else begin
      rd_addr[int'(v.ch)*AW +: AW] = v.addr;
      rd_req[v.ch] = 1'b1;
    end
    for (int c = 1; c <= 40 && t_fin < 0; c++) begin
      @(negedge clk);
      if (v.wr) begin
        if (wr_ack) begin t_ack = c; wr_req = 1'b0; end
        if (!ram_we_n) n_stb++;
        if (wr_done) t_fin = c;
      end else begin
        if (rd_ack[v.ch]) begin t_ack = c; rd_req[v.ch] = 1'b0; end
        if (!ram_oe_n) n_stb++;
        if (rd_valid[v.ch]) t_fin = c;
      end
    end
    wr_req = 1'b0;
    rd_req = '0;
    lat = bp ? 1 : W + 2;
    stb = bp ? 0 : W + 1;
    chk({tag, "_ack"}, t_ack, 1);
    chk({tag, "_lat"}, t_fin - t_ack, lat);
    chk({tag, "_stb"}, n_stb, stb);
    if (v.wr) begin
      chk({tag, "_mem"}, mem[v.addr[7:0]], v.data);
      tb_wv = 1'b1;
      tb_wa = v.addr;
    end else begin
      chk({tag, "_data"}, rd_data[int'(v.ch)*DW +: DW], v.exp);
    end
  endtask

  initial begin
    int ord [6];
    int g, last_v, wa, wd, ra, rv, dn;
    bit seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

    vecs[0] = '{1'b1, 2'd0, 20'h00010, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 2'd0, 20'h00010, 32'h0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 2'd1, 20'h00005, 32'h0, 32'h1000_0005};
    vecs[3] = '{1'b0, 2'd2, 20'h0003F, 32'h0, 32'h1000_003F};
    vecs[4] = '{1'b1, 2'd0, 20'h00005, 32'h1234_5678, 32'h0};
    vecs[5] = '{1'b0, 2'd2, 20'h00005, 32'h0, 32'h1234_5678};
    vecs[6] = '{1'b0, 2'd1, 20'h00010, 32'h0, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 2'd0, 20'h000FF, 32'h0000_0000, 32'h0};
    vecs[8] = '{1'b0, 2'd0, 20'h000FF, 32'h0, 32'h0000_0000};
    vecs[9] = '{1'b0, 2'd0, 20'h000FE, 32'h0, 32'h1000_00FE};

    // Reset state, then idle with no requests.
    repeat (2) @(negedge clk);
    chk("rst_in_strb", {30'd0, ram_oe_n, ram_we_n}, 32'd3);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_strb", {30'd0, ram_oe_n, ram_we_n}, 32'd3);
      chk("idle_hs", {24'd0, rd_ack, rd_valid, wr_ack, wr_done},
          32'd0);
      chk("idle_bus", {31'd0, dut.ram_drive}, 32'd0);
    end
    chk("idle_addr", {12'd0, ram_addr}, 32'd0);
    chk("idle_rdata", {31'd0, rd_data == '0}, 32'd1);
    chk("idle_ce", {31'd0, ram_ce_n}, 32'd0);

    // Round robin with all three requests held.
    ord = '{0, 1, 2, 0, 1, 2};
    g = 0;
    last_v = -100;
    @(negedge clk);
    rd_addr = {20'h00003, 20'h00002, 20'h00001};
    rd_req = 3'b111;
    for (int c = 1; c <= 200 && g < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (rd_valid[2'(k)]) begin
          last_v = c;
          chk("rr_data", rd_data[k*DW +: DW], 32'h1000_0001 + k);
        end
      end
      if (rd_ack != '0) begin
        chk("rr_grant", {29'd0, rd_ack}, 32'd1 << ord[g]);
        if (g > 0) chk("rr_gap", c - last_v, 1);
        g++;
      end
    end
    rd_req = '0;
    chk("rr_count", g, 6);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (rd_valid[2'(k)])
          chk("rr_data", rd_data[k*DW +: DW], 32'h1000_0001 + k);
      end
    end

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("v%0d", i), vecs[i]);

    // Write and read of the same address rise together.
    @(negedge clk);
    wr_addr = 20'h00020;
    wr_data = 32'hA5A5_5A5A;
    rd_addr[AW +: AW] = 20'h00020;
    wr_req = 1'b1;
    rd_req[1] = 1'b1;
    wa = -1; wd = -1; ra = -1; rv = -1;
    for (int c = 1; c <= 60 && rv < 0; c++) begin
      @(negedge clk);
      if (wr_ack) begin wa = c; wr_req = 1'b0; end
      if (wr_done) wd = c;
      if (rd_ack[1]) begin ra = c; rd_req[1] = 1'b0; end
      if (rd_valid[1]) rv = c;
    end
    wr_req = 1'b0;
    rd_req = '0;
    tb_wv = 1'b1;
    tb_wa = 20'h00020;
    chk("sim_wack", wa, 1);
    chk("sim_order", ra - wd, 2);
    chk("sim_rlat", rv - ra, byp(20'h00020) ? 1 : W + 2);
    chk("sim_data", rd_data[DW +: DW], 32'hA5A5_5A5A);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    wr_addr = 20'h00030;
    wr_data = 32'hCAFE_F00D;
    wr_req = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (wr_ack) wr_req = 1'b0;
      if (!ram_we_n) seen = 1'b1;
    end
    wr_req = 1'b0;
    chk("rm_strobe", {31'd0, seen}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rm_we", {31'd0, ram_we_n}, 32'd1);
    chk("rm_oe", {31'd0, ram_oe_n}, 32'd1);
    chk("rm_bus", {31'd0, dut.ram_drive}, 32'd0);
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (wr_done) dn++;
    end
    rst = 1'b0;
    tb_wv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wr_done) dn++;
    end
    chk("rm_nodone", dn, 0);
    run_vec("rm_rd", '{1'b0, 2'd2, 20'h00005, 32'h0, 32'h1234_5678});

    chk("no_overlap", {31'd0, overlap}, 32'd0);
    chk("one_ack", {31'd0, multi}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
